// File: rtl/pong_match_pkg.sv
// pong_match_pkg: shared types and constants for the Pong match controller
package pong_match_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} match_state_t;
  localparam int M_SCORE_W = 4;
  localparam int WIN_SCORE = 11;
  localparam int RND_NUM_W = 9;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 of x^16+x^14+x^13+x^11+1 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/pong_lfsr.sv
// pong_lfsr: free-running 16-bit Fibonacci LFSR for serve/deflection randomness
// Ports: clk_i clock, rst_i sync active-high reset (loads SEED), rnd_num_o low RND_W state bits.
module pong_lfsr
  import pong_match_pkg::*;
#(
  parameter logic [15:0] SEED  = LFSR_SEED,
  parameter int          RND_W = RND_NUM_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [RND_W-1:0] rnd_num_o
);
  logic [15:0] lfsr_q;
  always_ff @(posedge clk_i)
    if (rst_i) lfsr_q <= SEED;
    else lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign rnd_num_o = lfsr_q[RND_W-1:0];
endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: Pong match FSM, score counters with win detection and random source
// Ports: clk_i/rst_i clock and sync active-high reset; game_rst_i start button level;
// new_frame_i frame strobe; point_player_i/point_enemy_i point reports; game_en_o match running;
// player_score_o/enemy_score_o scores; winner_o {enemy,player} won; rnd_num_o random number;
// player_bcd_o/enemy_bcd_o BCD scores, driven only when PONG_SCORE_BCD_EN is defined.
module pong_match_ctrl
  import pong_match_pkg::*;
#(
  parameter int          M_SCORE_W = pong_match_pkg::M_SCORE_W,
  parameter int          WIN_SCORE = pong_match_pkg::WIN_SCORE,
  parameter int          RND_NUM_W = pong_match_pkg::RND_NUM_W,
  parameter logic [15:0] LFSR_SEED = pong_match_pkg::LFSR_SEED
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 game_rst_i,
  input  logic                 new_frame_i,
  input  logic                 point_player_i,
  input  logic                 point_enemy_i,
  output logic                 game_en_o,
  output logic [M_SCORE_W-1:0] player_score_o,
  output logic [M_SCORE_W-1:0] enemy_score_o,
  output logic [1:0]           winner_o,
  output logic [RND_NUM_W-1:0] rnd_num_o,
  output logic [7:0]           player_bcd_o,
  output logic [7:0]           enemy_bcd_o
);
  localparam logic [M_SCORE_W-1:0] WIN = M_SCORE_W'(WIN_SCORE);
  match_state_t         state_q;
  logic                 game_rst_q, game_en_q;
  logic [M_SCORE_W-1:0] player_score_q, enemy_score_q;
  logic [1:0]           winner_q, win;
  logic                 start, score_en;
  assign start    = game_rst_i & ~game_rst_q;
  assign win      = {enemy_score_q == WIN, player_score_q == WIN};
  assign score_en = (state_q == PLAY) & new_frame_i;
  // The edge register tracks the button even during reset, so a press held
  // through reset is not mistaken for a fresh start once reset releases.
  always_ff @(posedge clk_i) game_rst_q <= game_rst_i;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q        <= IDLE;
      game_en_q      <= 1'b0;
      player_score_q <= '0;
      enemy_score_q  <= '0;
      winner_q       <= 2'b00;
    end else if (start) begin
      state_q        <= PLAY;
      game_en_q      <= 1'b1;
      player_score_q <= '0;
      enemy_score_q  <= '0;
      winner_q       <= 2'b00;
    end else begin
      if (state_q == PLAY && |win) begin
        state_q   <= OVER;
        game_en_q <= 1'b0;
        winner_q  <= win;
      end
      if (score_en && point_player_i && !win[0]) player_score_q <= player_score_q + 1'b1;
      if (score_en && point_enemy_i && !win[1]) enemy_score_q <= enemy_score_q + 1'b1;
    end
  assign game_en_o      = game_en_q;
  assign player_score_o = player_score_q;
  assign enemy_score_o  = enemy_score_q;
  assign winner_o       = winner_q;
`ifdef PONG_SCORE_BCD_EN
  // double dabble into two BCD digits
  function automatic logic [7:0] to_bcd(input logic [M_SCORE_W-1:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = M_SCORE_W - 1; i >= 0; i--) begin
      if (r[3:0] > 4'd4) r[3:0] = r[3:0] + 4'd3;
      if (r[7:4] > 4'd4) r[7:4] = r[7:4] + 4'd3;
      r = {r[6:0], b[i]};
    end
    return r;
  endfunction
  assign player_bcd_o = to_bcd(player_score_q);
  assign enemy_bcd_o  = to_bcd(enemy_score_q);
`else
  assign player_bcd_o = 8'h00;
  assign enemy_bcd_o  = 8'h00;
`endif
  pong_lfsr #(.SEED(LFSR_SEED), .RND_W(RND_NUM_W)) u_lfsr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rnd_num_o(rnd_num_o)
  );
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed and random checks of pong_match_ctrl against a rule-level model
module tb_pong_match_ctrl;
  import pong_match_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1, game_rst = 1'b0, new_frame = 1'b0, pp = 1'b0, pe = 1'b0;
  logic game_en;
  logic [3:0] ps, es;
  logic [1:0] winner;
  logic [8:0] rnd;
  logic [7:0] pbcd, ebcd;
  int compared = 0, mismatched = 0;
  int m_mode, m_ps, m_es, m_win, m_lfsr, zero_hits;
  bit m_prev;
  always #5 clk = ~clk;
  pong_match_ctrl dut (
    .clk_i(clk), .rst_i(rst), .game_rst_i(game_rst), .new_frame_i(new_frame),
    .point_player_i(pp), .point_enemy_i(pe), .game_en_o(game_en),
    .player_score_o(ps), .enemy_score_o(es), .winner_o(winner), .rnd_num_o(rnd),
    .player_bcd_o(pbcd), .enemy_bcd_o(ebcd)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int bcd(input int s);
`ifdef PONG_SCORE_BCD_EN
    return ((s / 10) << 4) | (s % 10);
`else
    return 0 * s;
`endif
  endfunction
  // Rule-level model: mode 0 idle, 1 playing, 2 match over.
  function automatic void model_edge();
    int fb;
    bit start, playing, wp, we;
    start = game_rst && !m_prev;
    m_prev = game_rst;
    if (rst) begin
      m_mode = 0; m_ps = 0; m_es = 0; m_win = 0; m_lfsr = 'hACE1;
      return;
    end
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr * 2) + fb) % 65536;
    if (start) begin
      m_mode = 1; m_ps = 0; m_es = 0; m_win = 0;
      return;
    end
    playing = (m_mode == 1);
    wp = (m_ps == 11);
    we = (m_es == 11);
    if (playing && (wp || we)) begin
      m_mode = 2;
      m_win = (wp ? 1 : 0) + (we ? 2 : 0);
    end
    if (playing && new_frame && pp && m_ps < 11) m_ps++;
    if (playing && new_frame && pe && m_es < 11) m_es++;
  endfunction
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("game_en", game_en, m_mode == 1);
    check("player_score", ps, m_ps);
    check("enemy_score", es, m_es);
    check("winner", winner, m_win);
    check("rnd_num", rnd, m_lfsr % 512);
    check("player_bcd", pbcd, bcd(m_ps));
    check("enemy_bcd", ebcd, bcd(m_es));
  endtask
  task automatic press();
    game_rst = 1'b0; tick();
    game_rst = 1'b1; tick();
    game_rst = 1'b0;
  endtask
  task automatic points(input int n, input bit p, input bit e);
    new_frame = 1'b1; pp = p; pe = e;
    repeat (n) tick();
    new_frame = 1'b0; pp = 1'b0; pe = 1'b0;
  endtask
  initial begin
    m_prev = 1'b0;
    m_lfsr = 'hACE1;
    rst = 1'b1; game_rst = 1'b1;
    tick(); tick();
    check("reset_rnd", rnd, 9'h0E1);
    check("reset_game_en", game_en, 1'b0);
    rst = 1'b0;
    repeat (4) tick();
    check("held_no_start", game_en, 1'b0);
    press();
    check("start_en", game_en, 1'b1);
    points(3, 1'b1, 1'b0);
    check("player_3", ps, 4'd3);
    pp = 1'b1; tick(); tick(); pp = 1'b0;
    check("no_frame_ignored", ps, 4'd3);
    points(7, 1'b1, 1'b0);
    points(10, 1'b0, 1'b1);
    points(1, 1'b1, 1'b1);
    check("both_11", {ps, es}, 8'hBB);
    tick();
    check("over_winner", winner, 2'b11);
    check("over_en", game_en, 1'b0);
    points(3, 1'b1, 1'b1);
    check("over_hold", {ps, es}, 8'hBB);
    press();
    points(4, 1'b0, 1'b1);
    points(11, 1'b1, 1'b0);
    tick();
    check("over_11_4", {ps, es, winner}, {4'd11, 4'd4, 2'b01});
`ifdef PONG_SCORE_BCD_EN
    check("bcd_11", pbcd, 8'h11);
`else
    check("bcd_off", pbcd, 8'h00);
`endif
    press();
    check("restart_from_over", {game_en, ps, es, winner}, {1'b1, 10'd0});
    points(5, 1'b1, 1'b0);
    points(7, 1'b0, 1'b1);
    press();
    check("restart_mid_play", {game_en, ps, es}, {1'b1, 8'd0});
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      game_rst = ($urandom_range(0, 59) == 0);
      new_frame = $urandom_range(0, 1);
      pp = ($urandom_range(0, 2) == 0);
      pe = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst = 1'b1; game_rst = 1'b0; new_frame = 1'b0; pp = 1'b0; pe = 1'b0;
    tick();
    rst = 1'b0;
    zero_hits = 0;
    for (int i = 0; i < 65535; i++) begin
      tick();
      if (dut.u_lfsr.lfsr_q == 16'h0000) zero_hits++;
    end
    check("lfsr_never_zero", zero_hits, 0);
    check("lfsr_period", dut.u_lfsr.lfsr_q, LFSR_SEED);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
